// File: rtl/mmio_ui_controller_if.sv
// Load/store bus between the I/O address decoder and the user-I/O peripheral.
// Combinational read data; no backpressure, every access completes in its cycle.
interface mmio_ui_controller_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wrData;
  logic             wrEn;
  logic             rdEn;
  logic [DBITS-1:0] rdData;

  modport master (output addr, wrData, wrEn, rdEn, input rdData);
  modport slave  (input addr, wrData, wrEn, rdEn, output rdData);
endinterface

// File: rtl/mmio_ui_controller.sv
// Memory-mapped user I/O: HEX/LEDR registers, key capture, debounced switches, tick timer, irqs.
// Writes act at the strobed edge, reads are combinational; no backpressure (single-cycle access).
module mmio_ui_controller #(
  parameter int DBITS           = 32,
  parameter int KEY_BITS        = 4,
  parameter int SW_BITS         = 10,
  parameter int LEDR_BITS       = 10,
  parameter int HEX_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int TICK_CYCLES     = 100000,
  parameter logic [DBITS-1:0] ADDR_HEX   = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR  = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_KEY   = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW    = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_TCNT  = 32'hF0000020,
  parameter logic [DBITS-1:0] ADDR_TLIM  = 32'hF0000024,
  parameter logic [DBITS-1:0] ADDR_KCTRL = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL = 32'hF0000114,
  parameter logic [DBITS-1:0] ADDR_TCTL  = 32'hF0000120
) (
  input  logic                    clk,
  input  logic                    reset,
  mmio_ui_controller_if.slave     bus,
  input  logic [KEY_BITS-1:0]     KEY,
  input  logic [SW_BITS-1:0]      SW,
  output logic [LEDR_BITS-1:0]    LEDR,
  output logic [7*HEX_DIGITS-1:0] HEX,
  output logic                    irq_key,
  output logic                    irq_sw,
  output logic                    irq_timer
);

  localparam int HEX_BITS = 4 * HEX_DIGITS;
  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PS_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_CYCLES - 1);
  localparam int RDY_BIT = 0;
  localparam int OVR_BIT = 2;
  localparam int IE_BIT  = 8;

  // Status triples are packed {ie, overrun, ready}.
  function automatic logic [2:0] statusNext(
    input logic [2:0]       cur,
    input logic             evt,
    input logic             clr,
    input logic             wr,
    input logic [DBITS-1:0] d
  );
    logic rdy;
    logic ovr;
    logic ie;
    rdy = cur[0];
    ovr = cur[1];
    ie  = cur[2];
    if (wr) begin
      ie = d[IE_BIT];
      if (!d[OVR_BIT]) ovr = 1'b0;
    end
    if (clr) rdy = 1'b0;
    if (evt) begin
      if (cur[0] && !clr) ovr = 1'b1;
      rdy = 1'b1;
    end
    return {ie, ovr, rdy};
  endfunction

  function automatic logic [DBITS-1:0] statusWord(input logic [2:0] s);
    logic [DBITS-1:0] w;
    w          = '0;
    w[RDY_BIT] = s[0];
    w[OVR_BIT] = s[1];
    w[IE_BIT]  = s[2];
    return w;
  endfunction

  function automatic logic [6:0] segDecode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [HEX_BITS-1:0]  hexReg;
  logic [LEDR_BITS-1:0] ledrReg;
  logic [KEY_BITS-1:0]  keySync1, keySync2;
  logic [SW_BITS-1:0]   swSync1, swSync2, sData;
  logic [DB_W-1:0]      dbCnt;
  logic [PS_W-1:0]      preCnt;
  logic [DBITS-1:0]     tCnt, tLim;
  logic [2:0]           keyStat, swStat, tmrStat;

  logic wrHex, wrLedr, wrTcnt, wrTlim, wrKctrl, wrSctrl, wrTctl;
  logic rdKey, rdSw;
  logic keyChange, swChange, swStable, swLoad;
  logic tick, limitHit, timerEvt;

  assign wrHex   = bus.wrEn && (bus.addr == ADDR_HEX);
  assign wrLedr  = bus.wrEn && (bus.addr == ADDR_LEDR);
  assign wrTcnt  = bus.wrEn && (bus.addr == ADDR_TCNT);
  assign wrTlim  = bus.wrEn && (bus.addr == ADDR_TLIM);
  assign wrKctrl = bus.wrEn && (bus.addr == ADDR_KCTRL);
  assign wrSctrl = bus.wrEn && (bus.addr == ADDR_SCTRL);
  assign wrTctl  = bus.wrEn && (bus.addr == ADDR_TCTL);
  assign rdKey   = bus.rdEn && (bus.addr == ADDR_KEY);
  assign rdSw    = bus.rdEn && (bus.addr == ADDR_SW);

  assign keyChange = (keySync1 != keySync2);

  // The debounce window restarts whenever stage 2 is about to move, so a
  // new value is only accepted after it has held for the full count.
  assign swChange = (swSync1 != swSync2);
  assign swStable = !swChange && (swSync2 != sData);
  assign swLoad   = swStable && (dbCnt == DB_LAST);

  assign tick     = (preCnt == PS_LAST);
  assign limitHit = tick && (tLim != '0) && (tCnt == tLim - DBITS'(1));
  assign timerEvt = limitHit && !wrTcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      hexReg   <= '0;
      ledrReg  <= '0;
      keySync1 <= '0;
      keySync2 <= '0;
      keyStat  <= '0;
    end else begin
      if (wrHex)  hexReg  <= bus.wrData[HEX_BITS-1:0];
      if (wrLedr) ledrReg <= bus.wrData[LEDR_BITS-1:0];
      keySync1 <= ~KEY;
      keySync2 <= keySync1;
      keyStat  <= statusNext(keyStat, keyChange, rdKey, wrKctrl, bus.wrData);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      swSync1 <= '0;
      swSync2 <= '0;
      sData   <= '0;
      dbCnt   <= '0;
      swStat  <= '0;
    end else begin
      swSync1 <= SW;
      swSync2 <= swSync1;
      if (!swStable || swLoad) dbCnt <= '0;
      else                     dbCnt <= dbCnt + DB_W'(1);
      if (swLoad) sData <= swSync2;
      swStat <= statusNext(swStat, swLoad, rdSw, wrSctrl, bus.wrData);
    end
  end

  // A TCNT store also realigns the prescaler so the next tick is a full period away.
  always_ff @(posedge clk) begin
    if (reset) begin
      preCnt  <= '0;
      tCnt    <= '0;
      tLim    <= '0;
      tmrStat <= '0;
    end else begin
      if (wrTcnt) begin
        tCnt   <= bus.wrData;
        preCnt <= '0;
      end else begin
        preCnt <= tick ? '0 : preCnt + PS_W'(1);
        if (tick) tCnt <= limitHit ? '0 : tCnt + DBITS'(1);
      end
      if (wrTlim) tLim <= bus.wrData;
      tmrStat <= statusNext(tmrStat, timerEvt, wrTctl && !bus.wrData[RDY_BIT],
                            wrTctl, bus.wrData);
    end
  end

  always_comb begin
    bus.rdData = '0;
    case (bus.addr)
      ADDR_HEX:   bus.rdData = DBITS'(hexReg);
      ADDR_LEDR:  bus.rdData = DBITS'(ledrReg);
      ADDR_KEY:   bus.rdData = DBITS'(keySync2);
      ADDR_SW:    bus.rdData = DBITS'(sData);
      ADDR_TCNT:  bus.rdData = tCnt;
      ADDR_TLIM:  bus.rdData = tLim;
      ADDR_KCTRL: bus.rdData = statusWord(keyStat);
      ADDR_SCTRL: bus.rdData = statusWord(swStat);
      ADDR_TCTL:  bus.rdData = statusWord(tmrStat);
      default:    bus.rdData = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < HEX_DIGITS; gi++) begin : g_hex
      assign HEX[7*gi +: 7] = segDecode(hexReg[4*gi +: 4]);
    end
  endgenerate

  assign LEDR      = ledrReg;
  assign irq_key   = keyStat[0] & keyStat[2];
  assign irq_sw    = swStat[0] & swStat[2];
  assign irq_timer = tmrStat[0] & tmrStat[2];

endmodule

// File: tb/tb_mmio_ui_controller.sv
// Bench for mmio_ui_controller: register table plus key, debounce, timer and reset sequences.
module tb_mmio_ui_controller;

  localparam logic [31:0] A_HEX   = 32'hF0000000;
  localparam logic [31:0] A_LEDR  = 32'hF0000004;
  localparam logic [31:0] A_KEY   = 32'hF0000010;
  localparam logic [31:0] A_SW    = 32'hF0000014;
  localparam logic [31:0] A_TCNT  = 32'hF0000020;
  localparam logic [31:0] A_TLIM  = 32'hF0000024;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;
  localparam logic [31:0] A_TCTL  = 32'hF0000120;
  localparam logic [27:0] HEX_ZERO = {4{7'b1000000}};
  localparam logic [27:0] HEX_12AF = {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = '0;
  logic [9:0]  LEDR;
  logic [27:0] HEX;
  logic        irq_key, irq_sw, irq_timer;

  mmio_ui_controller_if #(.DBITS(32)) bus();

  mmio_ui_controller #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .KEY(KEY),
    .SW(SW),
    .LEDR(LEDR),
    .HEX(HEX),
    .irq_key(irq_key),
    .irq_sw(irq_sw),
    .irq_timer(irq_timer)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sbQ[$];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr   = a;
    bus.wrData = d;
    bus.wrEn   = 1'b1;
    step();
    bus.wrEn   = 1'b0;
  endtask

  task automatic rdSide(input logic [31:0] a);
    bus.addr = a;
    bus.rdEn = 1'b1;
    step();
    bus.rdEn = 1'b0;
  endtask

  // Expected read data is queued as the address is driven and compared once rdData settles.
  task automatic expectRd(input string name, input logic [31:0] a, input logic [31:0] exp);
    sb_t e;
    sb_t got;
    e.name = name;
    e.exp  = exp;
    bus.addr = a;
    sbQ.push_back(e);
    #1;
    got = sbQ.pop_front();
    check(got.name, {32'h0, bus.rdData}, {32'h0, got.exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int expT[6];
    expT = '{0, 1, 1, 2, 2, 0};
    vecs[0]  = '{"hex_wr",     A_HEX,   32'h000012AF, 32'h000012AF};
    vecs[1]  = '{"ledr_wr",    A_LEDR,  32'h000003FF, 32'h000003FF};
    vecs[2]  = '{"ledr_trunc", A_LEDR,  32'hABCD5555, 32'h00000155};
    vecs[3]  = '{"kctrl_all1", A_KCTRL, 32'hFFFFFFFF, 32'h00000100};
    vecs[4]  = '{"kctrl_zero", A_KCTRL, 32'h00000000, 32'h00000000};
    vecs[5]  = '{"sctrl_wr",   A_SCTRL, 32'h00000105, 32'h00000100};
    vecs[6]  = '{"sctrl_zero", A_SCTRL, 32'h00000000, 32'h00000000};
    vecs[7]  = '{"tctl_all1",  A_TCTL,  32'hFFFFFFFF, 32'h00000100};
    vecs[8]  = '{"tctl_zero",  A_TCTL,  32'h00000000, 32'h00000000};
    vecs[9]  = '{"kdata_ro",   A_KEY,   32'h0000000F, 32'h00000000};
    vecs[10] = '{"sdata_ro",   A_SW,    32'h000003FF, 32'h00000000};
    vecs[11] = '{"unmapped",   32'hF0000008, 32'hFFFFFFFF, 32'h00000000};
    vecs[12] = '{"tlim_wr",    A_TLIM,  32'hDEADBEEF, 32'hDEADBEEF};

    bus.addr = '0; bus.wrData = '0; bus.wrEn = 1'b0; bus.rdEn = 1'b0;
    reset = 1'b1;
    steps(2);
    reset = 1'b0;

    check("rst_hex", HEX, HEX_ZERO);
    check("rst_ledr", LEDR, 0);
    check("rst_irq", {irq_key, irq_sw, irq_timer}, 0);
    expectRd("rst_kdata", A_KEY, 0);

    for (int i = 0; i < 13; i++) begin
      wr(vecs[i].addr, vecs[i].data);
      expectRd(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end
    check("hex_glyphs", HEX, HEX_12AF);
    check("ledr_pins_trunc", LEDR, 10'h155);
    wr(A_LEDR, 32'h3FF);
    check("ledr_pins", LEDR, 10'h3FF);

    // Key capture, overrun, read-clear, and change coinciding with a read.
    wr(A_KCTRL, 32'h100);
    KEY = 4'b1110;
    step();
    expectRd("kdata_1edge", A_KEY, 0);
    step();
    expectRd("kdata_2edge", A_KEY, 1);
    expectRd("kctrl_ready", A_KCTRL, 32'h101);
    check("irq_key_set", irq_key, 1);
    KEY = 4'b1100;
    steps(2);
    expectRd("kdata_3", A_KEY, 3);
    expectRd("kctrl_overrun", A_KCTRL, 32'h105);
    rdSide(A_KEY);
    expectRd("kctrl_rdclr", A_KCTRL, 32'h104);
    check("irq_key_clr", irq_key, 0);
    wr(A_KCTRL, 32'h100);
    expectRd("kctrl_ovrclr", A_KCTRL, 32'h100);
    KEY = 4'b1111;
    steps(2);
    expectRd("kctrl_ready2", A_KCTRL, 32'h101);
    KEY = 4'b1110;
    step();
    rdSide(A_KEY);
    expectRd("kctrl_rd_coincide", A_KCTRL, 32'h101);
    rdSide(A_KEY);
    expectRd("kctrl_rdclr2", A_KCTRL, 32'h100);

    // Debounce: a 2-cycle glitch is rejected, a held value lands 2+4 edges later.
    wr(A_SCTRL, 32'h100);
    SW = 10'h001;
    steps(2);
    SW = 10'h000;
    steps(8);
    expectRd("sdata_glitch", A_SW, 0);
    expectRd("sctrl_glitch", A_SCTRL, 32'h100);
    SW = 10'h001;
    steps(5);
    expectRd("sdata_5edges", A_SW, 0);
    step();
    expectRd("sdata_6edges", A_SW, 1);
    expectRd("sctrl_ready", A_SCTRL, 32'h101);
    check("irq_sw_set", irq_sw, 1);
    rdSide(A_SW);
    expectRd("sctrl_rdclr", A_SCTRL, 32'h100);
    check("irq_sw_clr", irq_sw, 0);

    // Timer: limit 3, tick every 2 cycles.
    wr(A_TLIM, 32'd3);
    wr(A_TCTL, 32'h100);
    wr(A_TCNT, 32'd0);
    expectRd("tcnt_load0", A_TCNT, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      expectRd($sformatf("tcnt_seq%0d", i), A_TCNT, expT[i]);
      if (i == 4) expectRd("tctl_before_wrap", A_TCTL, 32'h100);
    end
    expectRd("tctl_wrap", A_TCTL, 32'h101);
    check("irq_timer_set", irq_timer, 1);
    steps(6);
    expectRd("tcnt_wrap2", A_TCNT, 0);
    expectRd("tctl_overrun", A_TCTL, 32'h105);
    step();
    wr(A_TCNT, 32'd7);
    expectRd("tcnt_write_beats_tick", A_TCNT, 7);
    steps(2);
    expectRd("tcnt_after_load", A_TCNT, 8);
    wr(A_TCTL, 32'h100);
    expectRd("tctl_swclr", A_TCTL, 32'h100);
    check("irq_timer_clr", irq_timer, 0);

    // Reset in the middle of a debounce count and a running timer.
    SW = 10'h2AA;
    steps(4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_hex", HEX, HEX_ZERO);
    check("mid_ledr", LEDR, 0);
    check("mid_irq", {irq_key, irq_sw, irq_timer}, 0);
    expectRd("mid_tcnt", A_TCNT, 0);
    expectRd("mid_tlim", A_TLIM, 0);
    expectRd("mid_sdata", A_SW, 0);
    expectRd("mid_kdata", A_KEY, 0);
    expectRd("mid_kctrl", A_KCTRL, 0);
    expectRd("mid_sctrl", A_SCTRL, 0);
    expectRd("mid_tctl", A_TCTL, 0);
    step();
    expectRd("post_rst_tcnt1", A_TCNT, 0);
    step();
    expectRd("post_rst_tcnt2", A_TCNT, 1);
    expectRd("post_rst_kctrl", A_KCTRL, 32'h001);
    check("post_rst_irq_key", irq_key, 0);
    steps(3);
    expectRd("post_rst_sdata5", A_SW, 0);
    step();
    expectRd("post_rst_sdata6", A_SW, 32'h2AA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
